fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that drives the program-counter unit's 2-bit command and load-target inputs and consumes its PC value. Each cycle it decides whether the PC holds, increments, loads a branch target or clears. It fetches the instruction at the current PC over a req/ack instruction-memory port and presents it to the decoder with a valid/ready handshake. It sits between the PC unit, instruction memory and the decode stage.

## Interface
- ADDR_W, 16, PC / instruction-memory address width
- INSTR_W, 16, instruction width
- TIMEOUT_W, 4, watchdog counter width; used only when the timeout macro is defined
- I_clk  in  1  single clock; all state updates on posedge
- I_rst_n  in  1  asynchronous, active-low reset
- I_pc  in  ADDR_W  current PC from the PC unit; the PC unit updates it on negedge
- o_pc_op  out  2  command to the PC unit: 00 hold, 01 increment, 10 load, 11 clear
- o_pc_target  out  ADDR_W  load value, meaningful when o_pc_op=10
- o_imem_req  out  1  fetch request, held until ack
- o_imem_addr  out  ADDR_W  fetch address, stable while req is high
- I_imem_ack  in  1  one-cycle response strobe
- I_imem_data  in  INSTR_W  instruction, valid with ack
- o_instr  out  INSTR_W  instruction to the decoder
- o_instr_valid  out  1  o_instr is valid
- I_instr_ready  in  1  decoder accepts the instruction
- I_branch_taken  in  1  one-cycle redirect pulse from execute
- I_branch_target  in  ADDR_W  redirect address
- I_halt  in  1  level; stop fetching
- o_halted  out  1  fetch is stopped
- o_fetch_err  out  1  sticky fetch-timeout flag

## Operation
- States:
  - CLEAR: drives op=11.
  - REQ: drives req=1 and waits for ack.
  - OUT: valid=1; waits for ready.
  - ADV: op issued in the previous cycle settles.
  - DRAIN: waits for the ack of an aborted fetch.
  - HALTED: o_halted=1.
- CLEAR → REQ after one cycle; o_imem_addr <= 0.
- REQ, ack=1 → OUT.
  - o_instr <= I_imem_data; req deasserts in the same edge.
- OUT, ready=1 → ADV with op=01.
- ADV → REQ.
  - op returns to 00.
  - o_imem_addr <= I_pc, which now carries the post-negedge updated value.
- Branch (I_branch_taken=1) in REQ, OUT or ADV:
  - op=10, o_pc_target <= I_branch_target.
  - o_instr_valid deasserts.
  - From REQ without ack in the same cycle → DRAIN: req stays high to keep the memory protocol intact; the returning data is discarded; ack → ADV.
  - Otherwise → ADV.
- Branch with ready in the same cycle in OUT:
  - The instruction counts as consumed.
  - The PC loads the target, not PC+1.
- Branch with ack in the same cycle in REQ: the data is discarded and the state goes to ADV.
- Branch in CLEAR or HALTED is ignored.
- Halt:
  - Sampled only in ADV. If I_halt=1 → HALTED with op=00.
  - HALTED → REQ when I_halt=0, with o_imem_addr <= I_pc.
- In every state not listed above, o_pc_op=00.
- Addresses wrap modulo 2^ADDR_W, as computed by the PC unit; this block does no arithmetic on the PC.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - state=CLEAR, o_pc_op=11
  - o_pc_target=0, o_imem_req=0, o_imem_addr=0
  - o_instr=0, o_instr_valid=0, o_halted=0, o_fetch_err=0
- Because op=11 is held during reset, the PC unit clears on every negedge while reset is asserted.
- o_pc_op is registered; the PC unit acts on it at the following negedge. I_pc reflects it at the next posedge.
- Minimum fetch cycle with zero-wait memory: 3 cycles per instruction (REQ, OUT, ADV). Each added memory wait adds 1 cycle.
- Branch to first request for the target: 2 cycles (ADV, then REQ) when no drain is needed.
- Reset mid-fetch abandons any outstanding request. The memory must also be reset.

## Configuration
- FETCH_CTRL_TIMEOUT_EN:
  - Defined: a TIMEOUT_W-bit counter runs in REQ and DRAIN. It clears on ack and on every state entry.
  - Reaching all-ones without ack sets o_fetch_err (sticky until reset) and moves to HALTED with req=0.
  - In that case HALTED is left only by reset; I_halt is ignored.
- Undefined: no counter, o_fetch_err tied 0, and the block waits for ack indefinitely.

## Structure
- Package fetch_pkg holds:
  - PC_HOLD=2'b00, PC_INC=2'b01, PC_LOAD=2'b10, PC_CLR=2'b11
  - the state encoding localparams (CLEAR, REQ, OUT, ADV, DRAIN, HALTED)
- One sub-module, fetch_watchdog, holds the timeout counter (ports: clk, rst_n, run, clear, expired). It is instantiated only under FETCH_CTRL_TIMEOUT_EN.

## Test plan
- Reset release with zero-wait memory and ready=1:
  - o_imem_addr sequence 0, 1, 2, 3 at 3-cycle spacing.
  - o_instr matches memory words 0..3.
- Memory with 2 wait cycles: req held for 3 cycles per fetch, addr stable throughout, exactly one op=01 per accepted instruction.
- Decoder backpressure: ready low for 4 cycles in OUT → valid and o_instr held, op stays 00, I_pc unchanged.
- Branch to 0x0040 while waiting for ack:
  - DRAIN entered; the stale data is never presented.
  - Next o_imem_addr=0x0040.
- Branch to 0x0100 and ready in the same cycle → op=10 (never 01), next addr=0x0100.
- With the macro defined and TIMEOUT_W=4, ack withheld → o_fetch_err=1 and o_halted=1 after 15 cycles in REQ. Reset clears both.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_pkg: PC-unit command codes and the fetch sequencer state encoding.
package fetch_pkg;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;
    localparam logic [1:0] PC_CLR  = 2'b11;

    localparam logic [2:0] CLEAR  = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] OUT    = 3'd2;
    localparam logic [2:0] ADV    = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;
    localparam logic [2:0] HALTED = 3'd5;

    typedef enum logic [2:0] {
        ST_CLEAR  = CLEAR,
        ST_REQ    = REQ,
        ST_OUT    = OUT,
        ST_ADV    = ADV,
        ST_DRAIN  = DRAIN,
        ST_HALTED = HALTED
    } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: PC-unit, instruction-memory, decode and control signals of the
// fetch sequencer. master = fetch_ctrl side, slave = surrounding pipeline.
interface fetch_ctrl_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  I_pc;
    logic [1:0]         o_pc_op;
    logic [ADDR_W-1:0]  o_pc_target;
    logic               o_imem_req;
    logic [ADDR_W-1:0]  o_imem_addr;
    logic               I_imem_ack;
    logic [INSTR_W-1:0] I_imem_data;
    logic [INSTR_W-1:0] o_instr;
    logic               o_instr_valid;
    logic               I_instr_ready;
    logic               I_branch_taken;
    logic [ADDR_W-1:0]  I_branch_target;
    logic               I_halt;
    logic               o_halted;
    logic               o_fetch_err;

    modport master (
        input  I_pc, I_imem_ack, I_imem_data, I_instr_ready,
               I_branch_taken, I_branch_target, I_halt,
        output o_pc_op, o_pc_target, o_imem_req, o_imem_addr,
               o_instr, o_instr_valid, o_halted, o_fetch_err
    );

    modport slave (
        output I_pc, I_imem_ack, I_imem_data, I_instr_ready,
               I_branch_taken, I_branch_target, I_halt,
        input  o_pc_op, o_pc_target, o_imem_req, o_imem_addr,
               o_instr, o_instr_valid, o_halted, o_fetch_err
    );
endinterface

// File: rtl/fetch_ctrl_watchdog.sv
// fetch_watchdog: fetch-timeout counter. Only built with FETCH_CTRL_TIMEOUT_EN.
// expired pulses on the edge where the counter would reach all-ones.
`ifdef FETCH_CTRL_TIMEOUT_EN
module fetch_watchdog #(
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] cnt;

    assign expired = run && !clear && (cnt == CNT_LAST);

    // Count cycles spent waiting for ack; restart on ack or state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CNT_ONE;
        end
    end
endmodule
`endif

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Commands the PC unit, fetches the
// word at the current PC over req/ack and hands it to decode via valid/ready.
// Optional fetch timeout: define FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int INSTR_W   = 16,
    parameter int TIMEOUT_W = 4
) (
    input logic          I_clk,
    input logic          I_rst_n,
    fetch_ctrl_if.master bus
);
    localparam logic [ADDR_W-1:0]  ADDR_ZERO  = '0;
    localparam logic [INSTR_W-1:0] INSTR_ZERO = '0;

    state_t state;
    logic   fetch_err;
    logic   wd_expired;

    assign bus.o_fetch_err = fetch_err;

`ifdef FETCH_CTRL_TIMEOUT_EN
    logic wd_run;
    logic wd_clear;

    // A REQ->DRAIN move counts as a state entry, so the branch restarts the count.
    assign wd_run   = (state == ST_REQ) || (state == ST_DRAIN);
    assign wd_clear = bus.I_imem_ack || !wd_run ||
                      ((state == ST_REQ) && bus.I_branch_taken);

    fetch_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
        .clk     (I_clk),
        .rst_n   (I_rst_n),
        .run     (wd_run),
        .clear   (wd_clear),
        .expired (wd_expired)
    );
`else
    logic unused_timeout_w;
    assign unused_timeout_w = ^TIMEOUT_W;
    assign wd_expired       = 1'b0;
`endif

    // Fetch sequencer with registered outputs; op falls back to hold every cycle.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state             <= ST_CLEAR;
            bus.o_pc_op       <= PC_CLR;
            bus.o_pc_target   <= ADDR_ZERO;
            bus.o_imem_req    <= 1'b0;
            bus.o_imem_addr   <= ADDR_ZERO;
            bus.o_instr       <= INSTR_ZERO;
            bus.o_instr_valid <= 1'b0;
            bus.o_halted      <= 1'b0;
            fetch_err         <= 1'b0;
        end else begin
            bus.o_pc_op <= PC_HOLD;
            case (state)
                ST_CLEAR: begin
                    bus.o_imem_req  <= 1'b1;
                    bus.o_imem_addr <= ADDR_ZERO;
                    state           <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.I_branch_taken) begin
                        // Redirect: data returned now or later is stale.
                        bus.o_pc_op       <= PC_LOAD;
                        bus.o_pc_target   <= bus.I_branch_target;
                        bus.o_instr_valid <= 1'b0;
                        if (bus.I_imem_ack) begin
                            bus.o_imem_req <= 1'b0;
                            state          <= ST_ADV;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (bus.I_imem_ack) begin
                        bus.o_instr       <= bus.I_imem_data;
                        bus.o_instr_valid <= 1'b1;
                        bus.o_imem_req    <= 1'b0;
                        state             <= ST_OUT;
                    end else if (wd_expired) begin
                        bus.o_imem_req <= 1'b0;
                        bus.o_halted   <= 1'b1;
                        fetch_err      <= 1'b1;
                        state          <= ST_HALTED;
                    end
                end
                ST_OUT: begin
                    // A branch wins over ready: the word is consumed but PC loads.
                    if (bus.I_branch_taken) begin
                        bus.o_pc_op       <= PC_LOAD;
                        bus.o_pc_target   <= bus.I_branch_target;
                        bus.o_instr_valid <= 1'b0;
                        state             <= ST_ADV;
                    end else if (bus.I_instr_ready) begin
                        bus.o_pc_op       <= PC_INC;
                        bus.o_instr_valid <= 1'b0;
                        state             <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    // I_pc now reflects the op issued on entry to this state.
                    if (bus.I_branch_taken) begin
                        bus.o_pc_op     <= PC_LOAD;
                        bus.o_pc_target <= bus.I_branch_target;
                    end else if (bus.I_halt) begin
                        bus.o_halted <= 1'b1;
                        state        <= ST_HALTED;
                    end else begin
                        bus.o_imem_req  <= 1'b1;
                        bus.o_imem_addr <= bus.I_pc;
                        state           <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (bus.I_imem_ack) begin
                        bus.o_imem_req <= 1'b0;
                        state          <= ST_ADV;
                    end else if (wd_expired) begin
                        bus.o_imem_req <= 1'b0;
                        bus.o_halted   <= 1'b1;
                        fetch_err      <= 1'b1;
                        state          <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    // After a timeout only reset leaves this state.
                    if (!fetch_err && !bus.I_halt) begin
                        bus.o_halted    <= 1'b0;
                        bus.o_imem_req  <= 1'b1;
                        bus.o_imem_addr <= bus.I_pc;
                        state           <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a negedge PC-unit model and
// a req/ack memory model with programmable wait states.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    fetch_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT_W(4)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEADBEEF;
    endfunction

    // Memory model: ack one cycle after mem_wait extra waits; no ack when disabled.
    int mem_wait = 0;
    bit mem_en   = 1'b1;
    int wcnt     = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.I_imem_ack  = 1'b0;
            bus.I_imem_data = '0;
            wcnt            = 0;
        end else if (bus.I_imem_ack) begin
            bus.I_imem_ack = 1'b0;
        end else if (bus.o_imem_req && mem_en) begin
            if (wcnt >= mem_wait) begin
                bus.I_imem_ack  = 1'b1;
                bus.I_imem_data = mem_word(bus.o_imem_addr);
                wcnt            = 0;
            end else begin
                wcnt++;
            end
        end
    end

    // PC unit model: acts on the registered op at negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.I_pc = '0;
        end else begin
            case (bus.o_pc_op)
                PC_INC:  bus.I_pc = bus.I_pc + 16'd1;
                PC_LOAD: bus.I_pc = bus.o_pc_target;
                PC_CLR:  bus.I_pc = '0;
                default: ;
            endcase
        end
    end

    // Monitor, sampled 4 time units after posedge (stimulus moves at +3).
    logic [31:0] addr_q[$];
    logic [31:0] rise_q[$];
    logic [31:0] reqlen_q[$];
    logic [31:0] hs_q[$];
    int inc_cnt, load_cnt, valid_cycles, stable_err, reqlen, cyc;
    logic prev_req;
    logic [15:0] prev_addr;
    always @(posedge clk) begin
        #4;
        cyc++;
        if (!rst_n) begin
            addr_q.delete(); rise_q.delete(); reqlen_q.delete(); hs_q.delete();
            inc_cnt = 0; load_cnt = 0; valid_cycles = 0; stable_err = 0;
            reqlen = 0; prev_req = 1'b0; prev_addr = '0;
        end else begin
            if (bus.o_imem_req) begin
                if (!prev_req) begin
                    addr_q.push_back(32'(bus.o_imem_addr));
                    rise_q.push_back(32'(cyc));
                    reqlen = 0;
                end else if (bus.o_imem_addr != prev_addr) begin
                    stable_err++;
                end
                reqlen++;
            end else if (prev_req) begin
                reqlen_q.push_back(32'(reqlen));
            end
            if (bus.o_instr_valid) valid_cycles++;
            if (bus.o_instr_valid && bus.I_instr_ready) hs_q.push_back(32'(bus.o_instr));
            if (bus.o_pc_op == PC_INC)  inc_cnt++;
            if (bus.o_pc_op == PC_LOAD) load_cnt++;
            prev_req  = bus.o_imem_req;
            prev_addr = bus.o_imem_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.I_branch_taken = 1'b0;
        repeat (3) step();
        check_eq("rst_op",     32'(bus.o_pc_op), 32'(PC_CLR));
        check_eq("rst_req",    32'(bus.o_imem_req), 0);
        check_eq("rst_addr",   32'(bus.o_imem_addr), 0);
        check_eq("rst_target", 32'(bus.o_pc_target), 0);
        check_eq("rst_instr",  32'(bus.o_instr), 0);
        check_eq("rst_valid",  32'(bus.o_instr_valid), 0);
        check_eq("rst_halted", 32'(bus.o_halted), 0);
        check_eq("rst_err",    32'(bus.o_fetch_err), 0);
        check_eq("rst_pc",     32'(bus.I_pc), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.I_instr_ready   = 1'b0;
        bus.I_branch_taken  = 1'b0;
        bus.I_branch_target = '0;
        bus.I_halt          = 1'b0;

        // Zero-wait memory, decoder always ready.
        mem_wait = 0; mem_en = 1'b1; bus.I_instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 40 && !(addr_q.size() >= 4 && hs_q.size() >= 4); i++) step();
        check_eq("t1_progress", 32'(hs_q.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t1_addr%0d", i), q_at(addr_q, i), 32'(i));
            check_eq($sformatf("t1_instr%0d", i), q_at(hs_q, i), 32'(mem_word(16'(i))));
        end
        for (int i = 1; i < 4; i++)
            check_eq($sformatf("t1_space%0d", i), q_at(rise_q, i) - q_at(rise_q, i - 1), 3);

        // Two wait states per fetch.
        mem_wait = 2;
        do_reset();
        for (int i = 0; i < 60 && hs_q.size() < 3; i++) step();
        step(); step();
        check_eq("t2_hs", 32'(hs_q.size()), 3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("t2_reqlen%0d", i), q_at(reqlen_q, i), 3);
        check_eq("t2_stable", 32'(stable_err), 0);
        check_eq("t2_inc", 32'(inc_cnt), 3);
        check_eq("t2_space", q_at(rise_q, 1) - q_at(rise_q, 0), 5);
        check_eq("t2_instr2", q_at(hs_q, 2), 32'(mem_word(16'd2)));

        // Decoder backpressure for 4 cycles.
        mem_wait = 0; bus.I_instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && !bus.o_instr_valid; i++) step();
        check_eq("t3_valid0", 32'(bus.o_instr_valid), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("t3_valid", 32'(bus.o_instr_valid), 1);
            check_eq("t3_instr", 32'(bus.o_instr), 32'(mem_word(16'd0)));
            check_eq("t3_op",    32'(bus.o_pc_op), 32'(PC_HOLD));
            check_eq("t3_pc",    32'(bus.I_pc), 0);
        end
        bus.I_instr_ready = 1'b1;
        for (int i = 0; i < 20 && addr_q.size() < 2; i++) step();
        check_eq("t3_next_addr", q_at(addr_q, 1), 1);
        check_eq("t3_hs0", q_at(hs_q, 0), 32'(mem_word(16'd0)));

        // Branch to 0x0040 while waiting for ack.
        mem_wait = 3;
        do_reset();
        for (int i = 0; i < 20 && !bus.o_imem_req; i++) step();
        bus.I_branch_taken = 1'b1; bus.I_branch_target = 16'h0040;
        step();
        bus.I_branch_taken = 1'b0;
        check_eq("t4_op_load", 32'(bus.o_pc_op), 32'(PC_LOAD));
        check_eq("t4_req_held", 32'(bus.o_imem_req), 1);
        for (int i = 0; i < 40 && addr_q.size() < 2; i++) step();
        check_eq("t4_next_addr", q_at(addr_q, 1), 32'h0040);
        check_eq("t4_no_valid", 32'(valid_cycles), 0);
        check_eq("t4_reqlen", q_at(reqlen_q, 0), 4);
        check_eq("t4_loads", 32'(load_cnt), 1);
        for (int i = 0; i < 40 && hs_q.size() < 1; i++) step();
        check_eq("t4_instr", q_at(hs_q, 0), 32'(mem_word(16'h0040)));

        // Branch to 0x0100 together with ready in OUT.
        mem_wait = 0; bus.I_instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && !bus.o_instr_valid; i++) step();
        bus.I_instr_ready = 1'b1; bus.I_branch_taken = 1'b1; bus.I_branch_target = 16'h0100;
        step();
        bus.I_branch_taken = 1'b0;
        check_eq("t5_op_load", 32'(bus.o_pc_op), 32'(PC_LOAD));
        for (int i = 0; i < 20 && addr_q.size() < 2; i++) step();
        check_eq("t5_next_addr", q_at(addr_q, 1), 32'h0100);
        check_eq("t5_no_inc", 32'(inc_cnt), 0);
        check_eq("t5_loads", 32'(load_cnt), 1);
        check_eq("t5_consumed", q_at(hs_q, 0), 32'(mem_word(16'd0)));
        for (int i = 0; i < 20 && hs_q.size() < 2; i++) step();
        check_eq("t5_instr", q_at(hs_q, 1), 32'(mem_word(16'h0100)));

        // Halt sampled in ADV, resume at current PC.
        bus.I_halt = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && !bus.o_halted; i++) step();
        check_eq("t6_halted", 32'(bus.o_halted), 1);
        check_eq("t6_fetches", 32'(addr_q.size()), 1);
        repeat (3) step();
        check_eq("t6_req_idle", 32'(bus.o_imem_req), 0);
        check_eq("t6_op_idle", 32'(bus.o_pc_op), 32'(PC_HOLD));
        bus.I_halt = 1'b0;
        step();
        check_eq("t6_resume_req", 32'(bus.o_imem_req), 1);
        check_eq("t6_resume_addr", 32'(bus.o_imem_addr), 1);
        check_eq("t6_unhalted", 32'(bus.o_halted), 0);

        // Ack withheld.
        mem_en = 1'b0;
        do_reset();
`ifdef FETCH_CTRL_TIMEOUT_EN
        for (int k = 0; k < 15; k++) step();
        check_eq("t7_err_early", 32'(bus.o_fetch_err), 0);
        check_eq("t7_halt_early", 32'(bus.o_halted), 0);
        step();
        check_eq("t7_err", 32'(bus.o_fetch_err), 1);
        check_eq("t7_halted", 32'(bus.o_halted), 1);
        check_eq("t7_req_drop", 32'(bus.o_imem_req), 0);
        repeat (3) step();
        check_eq("t7_sticky", 32'(bus.o_halted), 1);
`else
        repeat (20) step();
        check_eq("t7_no_err", 32'(bus.o_fetch_err), 0);
        check_eq("t7_still_req", 32'(bus.o_imem_req), 1);
        check_eq("t7_not_halted", 32'(bus.o_halted), 0);
        check_eq("t7_one_fetch", 32'(addr_q.size()), 1);
`endif
        mem_en = 1'b1;
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
